mem_port_arbiter: RTL and testbench

//  Shares the single data/instruction memory port between fetch (IF) and memory stage (MEM) of the RV32I pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter_if.sv | 23 ++
 rtl/mem_port_arbiter_wdt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/ready bus between the arbiter and a variable-latency memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_port_arbiter_wdt.sv
// Transaction watchdog: loadable down-counter, expired while the count is zero.
module mem_wdt #(
   parameter int W        = 6,
   parameter int LOAD_VAL = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt_q;

   // reload on every grant, count down while the memory has not answered
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= W'(LOAD_VAL);
      else if (en && (cnt_q != '0))
         cnt_q <= cnt_q - W'(1);
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the memory stage.
//
//  state  | meaning
//  IDLE   | no transaction outstanding, arbitrating
//  BUSY_I | fetch transaction outstanding on the memory bus
//  BUSY_D | load/store transaction outstanding on the memory bus
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYC    = 64,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IfReq,
   input  logic [ADDR_W-1:0] PCF,
   output logic [DATA_W-1:0] InstrF,
   output logic              IfReady,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] AddrM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [3:0]        ByteEnM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              Ready,
   output logic              BusErr,
   mem_port_arbiter_if.master mem
);

   localparam int BW = $clog2(MAX_DATA_BURST + 1);
   localparam int WW = $clog2(TIMEOUT_CYC);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

   arb_state_t    state_q, state_d;
   logic [BW-1:0] burst_q;
   logic          data_pend, if_pend;
   logic          grant_d, grant_i, done, abort;
   logic          wdt_en, wdt_expired;

   // a requester whose completion pulse is high still shows its old request level
   assign data_pend = (MemReadM | MemWriteM) & ~Ready;
   assign if_pend   = IfReq & ~IfReady;
   assign wdt_en    = (state_q != IDLE) & ~mem.mem_ready;

   mem_wdt #(
      .W        (WW),
      .LOAD_VAL (TIMEOUT_CYC - 1)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clear   (grant_d | grant_i),
      .en      (wdt_en),
      .expired (wdt_expired)
   );

   // arbitration and completion decode; while a data pulse is out and the burst
   // budget is not spent, fetch waits a cycle so a back-to-back data access keeps priority
   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      grant_i = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_pend && (!if_pend || (burst_q < BURST_MAX))) begin
               grant_d = 1'b1;
               state_d = BUSY_D;
            end else if (if_pend && !(Ready && (burst_q < BURST_MAX))) begin
               grant_i = 1'b1;
               state_d = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem.mem_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (wdt_expired) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, bus registers, burst counter and completion pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         burst_q       <= '0;
         Ready         <= 1'b0;
         IfReady       <= 1'b0;
         BusErr        <= 1'b0;
         InstrF        <= '0;
         ReadDataM     <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_be    <= '0;
      end else begin
         state_q <= state_d;
         Ready   <= 1'b0;
         IfReady <= 1'b0;
         BusErr  <= 1'b0;
         if (grant_d) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWriteM;
            mem.mem_addr  <= AddrM;
            mem.mem_wdata <= WriteDataM;
            mem.mem_be    <= MemWriteM ? ByteEnM : BE_WORD;
            if (if_pend)
               burst_q <= (burst_q == BURST_MAX) ? BURST_MAX : burst_q + BW'(1);
            else
               burst_q <= '0;
         end else if (grant_i) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= PCF;
            mem.mem_wdata <= '0;
            mem.mem_be    <= BE_WORD;
            burst_q       <= '0;
         end
         if (done || abort) begin
            mem.mem_req <= 1'b0;
            BusErr      <= abort;
            if (state_q == BUSY_I) begin
               IfReady <= 1'b1;
               InstrF  <= abort ? '0 : mem.mem_rdata;
            end else begin
               Ready <= 1'b1;
               if (abort)
                  ReadDataM <= '0;
               else if (!mem.mem_we)
                  ReadDataM <= mem.mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a programmable-latency memory model.
module tb_mem_port_arbiter;

   localparam int TO = 8;
   localparam int MB = 4;

   logic        clk;
   logic        rst, IfReq, MemReadM, MemWriteM;
   logic [31:0] PCF, AddrM, WriteDataM, InstrF, ReadDataM;
   logic [3:0]  ByteEnM;
   logic        IfReady, Ready, BusErr;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .MAX_DATA_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst), .IfReq(IfReq), .PCF(PCF), .InstrF(InstrF),
      .IfReady(IfReady), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .AddrM(AddrM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
      .ReadDataM(ReadDataM), .Ready(Ready), .BusErr(BusErr), .mem(mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        fetch;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          lat = 0;
   bit          inject_stray = 0;
   bit          force_en = 0;
   logic [31:0] force_data = 32'h0;
   int          busy_cnt = 0, run = 0, last_run = 0;
   logic [31:0] exp_rdm = 32'h0;
   int          cyc, nd, ni;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return force_en ? force_data : {a[15:0], ~a[15:0]};
   endfunction

   task automatic push(input bit f, input logic [31:0] d, input bit e_err);
      exp_t e;
      e.fetch = f;
      e.data  = d;
      e.err   = e_err;
      sb.push_back(e);
   endtask

   task automatic wait_pulse(input bit f, input int max_cyc, output int n);
      bit seen;
      seen = 0;
      n = 0;
      while (!seen && n < max_cyc) begin
         @(negedge clk);
         n++;
         seen = f ? IfReady : Ready;
      end
      check("pulse_seen", 32'(seen), 32'd1);
   endtask

   // memory model, grant checks and completion scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (mem_bus.mem_req) begin
         if (busy_cnt == 0) begin
            if (sb.size() == 0)
               check("grant_unexpected", 32'd1, 32'd0);
            else begin
               e = sb[0];
               if (e.fetch) begin
                  check("grant_addr_i", mem_bus.mem_addr, PCF);
                  check("grant_we_i", 32'(mem_bus.mem_we), 32'd0);
                  check("grant_be_i", 32'(mem_bus.mem_be), 32'hF);
               end else begin
                  check("grant_addr_d", mem_bus.mem_addr, AddrM);
                  check("grant_we_d", 32'(mem_bus.mem_we), 32'(MemWriteM));
                  check("grant_be_d", 32'(mem_bus.mem_be), MemWriteM ? 32'(ByteEnM) : 32'hF);
                  if (MemWriteM)
                     check("grant_wdata", mem_bus.mem_wdata, WriteDataM);
               end
            end
         end
         mem_bus.mem_ready = (lat >= 0) && (busy_cnt == lat);
         mem_bus.mem_rdata = mem_bus.mem_ready ? mem_word(mem_bus.mem_addr) : 32'hBAD0_0BAD;
         busy_cnt++;
         run++;
      end else begin
         if (run != 0) last_run = run;
         run      = 0;
         busy_cnt = 0;
         mem_bus.mem_ready = inject_stray;
         mem_bus.mem_rdata = 32'h5A5A_5A5A;
      end
      if (Ready && IfReady) check("both_pulses", 32'd1, 32'd0);
      if (BusErr && !(Ready || IfReady)) check("buserr_alone", 32'd1, 32'd0);
      if (Ready || IfReady) begin
         if (sb.size() == 0)
            check("pulse_unexpected", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("kind", 32'(IfReady), 32'(e.fetch));
            check("data", IfReady ? InstrF : ReadDataM, e.data);
            check("buserr", 32'(BusErr), 32'(e.err));
            if (e.err) check("wdt_req_cycles", last_run, TO);
         end
      end
   end

   initial begin
      rst = 1; IfReq = 0; MemReadM = 0; MemWriteM = 0;
      PCF = 32'h0; AddrM = 32'h0; WriteDataM = 32'h0; ByteEnM = 4'h0;
      mem_bus.mem_ready = 0; mem_bus.mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
      check("rst_ready", 32'(Ready), 32'd0);
      check("rst_ifready", 32'(IfReady), 32'd0);
      check("rst_buserr", 32'(BusErr), 32'd0);
      check("rst_instr", InstrF, 32'h0);
      check("rst_rdata", ReadDataM, 32'h0);
      check("rst_be", 32'(mem_bus.mem_be), 32'h0);
      rst = 0;
      @(negedge clk);

      // load, memory answers two cycles after mem_req
      force_en = 1; force_data = 32'hDEADBEEF; lat = 2;
      AddrM = 32'h0000_2000; MemReadM = 1;
      exp_rdm = 32'hDEADBEEF; push(0, 32'hDEADBEEF, 0);
      wait_pulse(0, 20, cyc);
      check("t1_latency", cyc, 4);
      MemReadM = 0; force_en = 0;
      @(negedge clk);

      // store, immediate ready, ReadDataM keeps the last load value
      lat = 0; AddrM = 32'h0000_0100; WriteDataM = 32'hCAFE_F00D; ByteEnM = 4'b0011;
      MemWriteM = 1; push(0, exp_rdm, 0);
      wait_pulse(0, 20, cyc);
      check("t3_latency", cyc, 2);
      MemWriteM = 0;
      @(negedge clk);

      // held fetch + held load: D,D,D,D,I,D
      lat = 1; AddrM = 32'h0000_2040; PCF = 32'h0000_1040;
      repeat (4) push(0, mem_word(32'h0000_2040), 0);
      push(1, mem_word(32'h0000_1040), 0);
      push(0, mem_word(32'h0000_2040), 0);
      exp_rdm = mem_word(32'h0000_2040);
      IfReq = 1; MemReadM = 1;
      nd = 0; ni = 0;
      for (int i = 0; i < 200 && !(nd == 5 && ni == 1); i++) begin
         @(negedge clk);
         if (IfReady) begin ni++; IfReq = 0; end
         if (Ready) begin nd++; if (nd == 5) MemReadM = 0; end
      end
      check("t2_data_done", nd, 5);
      check("t2_fetch_done", ni, 1);
      @(negedge clk);

      // fetch with a memory that never answers
      lat = -1; PCF = 32'h0000_1080; IfReq = 1; push(1, 32'h0, 1);
      wait_pulse(1, 40, cyc);
      check("t4_latency", cyc, TO + 1);
      check("t4_req_low", 32'(mem_bus.mem_req), 32'd0);
      IfReq = 0;
      @(negedge clk);

      // fetch request dropped while busy still completes
      lat = 3; PCF = 32'h0000_10C0; IfReq = 1; push(1, mem_word(32'h0000_10C0), 0);
      repeat (2) @(negedge clk);
      IfReq = 0;
      wait_pulse(1, 20, cyc);
      check("t7_latency", cyc, 3);
      @(negedge clk);

      // reset in the middle of a load
      lat = -1; AddrM = 32'h0000_2100; MemReadM = 1; push(0, 32'h0, 0);
      repeat (3) @(negedge clk);
      check("t5_busy", 32'(mem_bus.mem_req), 32'd1);
      sb.delete(); rst = 1; MemReadM = 0; exp_rdm = 32'h0;
      @(negedge clk);
      check("t5_mem_req", 32'(mem_bus.mem_req), 32'd0);
      check("t5_ready", 32'(Ready), 32'd0);
      check("t5_rdata", ReadDataM, 32'h0);
      check("t5_instr", InstrF, 32'h0);
      check("t5_we", 32'(mem_bus.mem_we), 32'd0);
      check("t5_addr", mem_bus.mem_addr, 32'h0);
      check("t5_be", 32'(mem_bus.mem_be), 32'h0);
      rst = 0;
      repeat (2) @(negedge clk);
      lat = 1; AddrM = 32'h0000_2104; MemReadM = 1; push(0, mem_word(32'h0000_2104), 0);
      wait_pulse(0, 20, cyc);
      check("t5_latency", cyc, 3);
      MemReadM = 0;
      @(negedge clk);

      // stray mem_ready while idle is ignored
      lat = 0; inject_stray = 1;
      repeat (2) @(negedge clk);
      inject_stray = 0;
      repeat (3) begin
         @(negedge clk);
         check("t6_req_idle", 32'(mem_bus.mem_req), 32'd0);
      end
      PCF = 32'h0000_1100; IfReq = 1; push(1, mem_word(32'h0000_1100), 0);
      wait_pulse(1, 20, cyc);
      check("t6_latency", cyc, 2);
      IfReq = 0;

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
